// File: rtl/traveler_cmd_encoder.sv
// traveler_cmd_encoder: debounces single-button presses into command codes queued in a FWFT FIFO.
// Optional auto-repeat while a button is held: define TRAVELER_CMD_AUTO_REPEAT_EN.
module traveler_cmd_encoder #(
    parameter int N_BTN = 5,
    parameter int CMD_W = 8,
    parameter logic [N_BTN*CMD_W-1:0] CMD_TABLE = {8'h42, 8'h22, 8'h12, 8'h0A, 8'h06},
    parameter int DEBOUNCE_CNT = 5000000,
    parameter int REPEAT_CNT = 25000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [CMD_W-1:0] cmd_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [CMD_W:0]   data,
    output logic [7:0]       drop_cnt
);
    localparam int IW = N_BTN > 1 ? $clog2(N_BTN) : 1;
    localparam int CNT_MAX = DEBOUNCE_CNT > REPEAT_CNT ? DEBOUNCE_CNT : REPEAT_CNT;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    logic [N_BTN-1:0] r_sync1, r_s;
    logic [1:0]       r_state, w_state_n;
    logic [IW-1:0]    r_id, w_id_n, w_k;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic             w_valid, w_match, w_fire, w_pop, w_full, w_push, w_drop;
    logic [CMD_W-1:0] w_code;
    logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [NW-1:0]    r_count;
    logic [CMD_W:0]   r_data;
    logic [7:0]       r_drop;
`ifdef TRAVELER_CMD_AUTO_REPEAT_EN
    logic [CW-1:0]    r_rcnt, w_rcnt_n;
`endif

    assign w_valid = |r_s && ~|(r_s & (r_s - N_BTN'(1)));
    assign w_match = r_s == (N_BTN'(1) << r_id);
    assign w_code = CMD_TABLE[r_id*CMD_W +: CMD_W];

    always_comb begin
        w_k = '0;
        for (int i = 0; i < N_BTN; i++)
            if (r_s[i]) w_k = IW'(i);
    end

    // Any state that loses its button re-evaluates the input exactly as IDLE would.
    always_comb begin
        w_state_n = w_valid ? ARMED : IDLE;
        w_id_n = w_valid ? w_k : r_id;
        w_cnt_n = '0;
        w_fire = 1'b0;
`ifdef TRAVELER_CMD_AUTO_REPEAT_EN
        w_rcnt_n = '0;
`endif
        if (r_state == ARMED && w_match) begin
            w_fire = r_cnt == CW'(DEBOUNCE_CNT);
            w_state_n = w_fire ? HELD : ARMED;
            w_cnt_n = w_fire ? '0 : r_cnt + CW'(1);
        end else if (r_state == HELD && w_match) begin
`ifdef TRAVELER_CMD_AUTO_REPEAT_EN
            w_fire = r_rcnt == CW'(REPEAT_CNT);
            w_rcnt_n = w_fire ? '0 : r_rcnt + CW'(1);
`else
            w_fire = 1'b0;
`endif
            w_state_n = HELD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_s <= '0;
            r_state <= IDLE;
            r_id <= '0;
            r_cnt <= '0;
        end else begin
            r_sync1 <= btn;
            r_s <= r_sync1;
            r_state <= w_state_n;
            r_id <= w_id_n;
            r_cnt <= w_cnt_n;
        end
    end

`ifdef TRAVELER_CMD_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rcnt <= '0;
        else r_rcnt <= w_rcnt_n;
    end
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop = cmd_valid & cmd_ready;
    assign w_full = r_count == NW'(FIFO_DEPTH);
    assign w_push = w_fire & (~w_full | w_pop);
    assign w_drop = w_fire & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
            r_count <= '0;
            r_data <= '0;
            r_drop <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_count <= r_count + NW'(w_push) - NW'(w_pop);
            if (w_fire) r_data <= {~r_data[CMD_W], w_code};
            if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_code;
    end

    assign cmd_valid = r_count != '0;
    assign cmd_data = cmd_valid ? r_mem[r_rp] : '0;
    assign data = r_data;
    assign drop_cnt = r_drop;
endmodule
